// File: rtl/xgmii_pkg.sv
// XGMII control characters, canned blocks and frame-generator state encoding,
// shared by the frame generator and the PHY benches.
package xgmii_pkg;

    localparam logic [7:0] XGMII_IDLE  = 8'h07;
    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_PRE   = 8'h55;
    localparam logic [7:0] XGMII_SFD   = 8'hD5;

    localparam logic [63:0] IDLE_BLOCK  = {8{XGMII_IDLE}};
    localparam logic [63:0] START_BLOCK = {XGMII_SFD, {6{XGMII_PRE}}, XGMII_START};
    localparam logic [63:0] TERM_BLOCK  = {{7{XGMII_IDLE}}, XGMII_TERM};

    localparam logic [7:0] CTRL_ALL   = 8'hFF;
    localparam logic [7:0] CTRL_START = 8'h01;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_TERM  = 3'd3;
    localparam logic [2:0] ST_IFG   = 3'd4;

    localparam logic [10:0] MIN_PAYLOAD = 11'd46;
    localparam logic [10:0] MAX_PAYLOAD = 11'd1500;

    // Keep the payload inside legal Ethernet sizes (FCS is never added).
    function automatic logic [10:0] clamp_payload(input logic [10:0] len);
        logic [10:0] res;
        res = len;
        if (len < MIN_PAYLOAD) begin
            res = MIN_PAYLOAD;
        end else if (len > MAX_PAYLOAD) begin
            res = MAX_PAYLOAD;
        end
        return res;
    endfunction

    function automatic logic [3:0] clamp_ifg(input logic [3:0] ifg);
        return (ifg == 4'd0) ? 4'd1 : ifg;
    endfunction

endpackage

// File: rtl/xgmii_frame_gen_if.sv
// XGMII transmit bus from the frame generator (master) towards the 10G PHY (slave).
interface xgmii_frame_gen_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8
);

    logic [DATA_WIDTH-1:0] xgmii_txd;
    logic [CTRL_WIDTH-1:0] xgmii_txc;

    modport master (output xgmii_txd, output xgmii_txc);
    modport slave  (input  xgmii_txd, input  xgmii_txc);

endinterface

// File: rtl/xgmii_term_mux.sv
// Builds the block carrying the terminate character: rem data lanes, then 0xFD,
// then idles. rem==0 yields the plain terminate block.
module xgmii_term_mux
    import xgmii_pkg::*;
(
    input  logic [2:0]  rem,
    input  logic [63:0] data_word,
    output logic [63:0] txd,
    output logic [7:0]  txc
);

    always_comb begin
        txd = IDLE_BLOCK;
        txc = CTRL_ALL;
        for (int n = 0; n < 8; n++) begin
            if (n < int'(rem)) begin
                txd[8*n +: 8] = data_word[8*n +: 8];
                txc[n]        = 1'b0;
            end else if (n == int'(rem)) begin
                txd[8*n +: 8] = XGMII_TERM;
                txc[n]        = 1'b1;
            end else begin
                txd[8*n +: 8] = XGMII_IDLE;
                txc[n]        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xgmii_frame_gen.sv
// XGMII test-frame generator: START/preamble, counting payload, terminate and a
// configurable inter-frame gap, all outputs registered one cycle behind the FSM.
module xgmii_frame_gen
    import xgmii_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8
) (
    input  logic              tx_clk,
    input  logic              tx_rst_n,
    input  logic              start,
    input  logic [10:0]       cfg_payload_len,
    input  logic [3:0]        cfg_ifg,
    input  logic              cfg_continuous,
    xgmii_frame_gen_if.master xgmii,
    output logic              busy,
    output logic [31:0]       frame_count
);

    logic [2:0]            state;
    logic [2:0]            state_d;
    logic [10:0]           rem;
    logic [10:0]           rem_d;
    logic [7:0]            byte_base;
    logic [7:0]            byte_base_d;
    logic [3:0]            ifg_len;
    logic [3:0]            ifg_len_d;
    logic [3:0]            ifg_cnt;
    logic [3:0]            ifg_cnt_d;
    logic                  frame_done;
    logic [DATA_WIDTH-1:0] txd_d;
    logic [CTRL_WIDTH-1:0] txc_d;
    logic [63:0]           data_word;
    logic [63:0]           term_txd;
    logic [7:0]            term_txc;

    // Lane n of the current data block carries payload byte (index + frame base) mod 256.
    always_comb begin
        data_word = '0;
        for (int n = 0; n < 8; n++) begin
            data_word[8*n +: 8] = byte_base + 8'(n);
        end
    end

    // In TERM the remainder has already been counted down to zero, giving the plain terminate block.
    xgmii_term_mux u_term_mux (
        .rem       (rem[2:0]),
        .data_word (data_word),
        .txd       (term_txd),
        .txc       (term_txc)
    );

    always_comb begin
        state_d     = state;
        rem_d       = rem;
        byte_base_d = byte_base;
        ifg_len_d   = ifg_len;
        ifg_cnt_d   = ifg_cnt;
        frame_done  = 1'b0;
        txd_d       = IDLE_BLOCK;
        txc_d       = CTRL_ALL;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                txd_d       = START_BLOCK;
                txc_d       = CTRL_START;
                rem_d       = clamp_payload(cfg_payload_len);
                byte_base_d = frame_count[7:0];
                ifg_len_d   = clamp_ifg(cfg_ifg);
                state_d     = ST_DATA;
            end
            ST_DATA: begin
                if (rem >= 11'd8) begin
                    txd_d       = data_word;
                    txc_d       = '0;
                    rem_d       = rem - 11'd8;
                    byte_base_d = byte_base + 8'd8;
                    if (rem == 11'd8) begin
                        state_d = ST_TERM;
                    end
                end else begin
                    txd_d      = term_txd;
                    txc_d      = term_txc;
                    frame_done = 1'b1;
                    ifg_cnt_d  = ifg_len;
                    state_d    = ST_IFG;
                end
            end
            ST_TERM: begin
                txd_d      = term_txd;
                txc_d      = term_txc;
                frame_done = 1'b1;
                ifg_cnt_d  = ifg_len;
                state_d    = ST_IFG;
            end
            ST_IFG: begin
                if (ifg_cnt <= 4'd1) begin
                    state_d = cfg_continuous ? ST_START : ST_IDLE;
                end else begin
                    ifg_cnt_d = ifg_cnt - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // busy is registered from the next state so it lines up with the state register itself.
    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            state           <= ST_IDLE;
            rem             <= '0;
            byte_base       <= '0;
            ifg_len         <= '0;
            ifg_cnt         <= '0;
            xgmii.xgmii_txd <= IDLE_BLOCK;
            xgmii.xgmii_txc <= CTRL_ALL;
            busy            <= 1'b0;
            frame_count     <= '0;
        end else begin
            state           <= state_d;
            rem             <= rem_d;
            byte_base       <= byte_base_d;
            ifg_len         <= ifg_len_d;
            ifg_cnt         <= ifg_cnt_d;
            xgmii.xgmii_txd <= txd_d;
            xgmii.xgmii_txc <= txc_d;
            busy            <= (state_d != ST_IDLE);
            frame_count     <= frame_count + 32'(frame_done);
        end
    end

endmodule

// File: tb/tb_xgmii_frame_gen.sv
// Self-checking bench for xgmii_frame_gen: table of frame lengths, hand-written
// reset/continuous sequences and random frames against a byte-stream model.
module tb_xgmii_frame_gen;
    import xgmii_pkg::*;

    typedef struct packed {
        logic [7:0]  c;
        logic [63:0] d;
    } blk_t;

    typedef struct {
        int         len;
        int         full;
        logic [7:0] last_c;
    } vec_t;

    logic        tx_clk;
    logic        tx_rst_n;
    logic        start;
    logic [10:0] cfg_payload_len;
    logic [3:0]  cfg_ifg;
    logic        cfg_continuous;
    logic        busy;
    logic [31:0] frame_count;

    int   checks = 0;
    int   errors = 0;
    int   exp_fc = 0;
    blk_t exp_q[$];

    xgmii_frame_gen_if #(.DATA_WIDTH(64)) xg_if ();

    xgmii_frame_gen #(.DATA_WIDTH(64)) dut (
        .tx_clk          (tx_clk),
        .tx_rst_n        (tx_rst_n),
        .start           (start),
        .cfg_payload_len (cfg_payload_len),
        .cfg_ifg         (cfg_ifg),
        .cfg_continuous  (cfg_continuous),
        .xgmii           (xg_if),
        .busy            (busy),
        .frame_count     (frame_count)
    );

    initial tx_clk = 1'b0;
    always #5 tx_clk = ~tx_clk;

    task automatic tick();
        @(posedge tx_clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Reference frame: START block, then the clamped payload followed by one 0xFD control
    // character, padded with idle control characters to whole 8-lane blocks.
    function automatic void modelFrame(input int len, input int fc);
        logic [7:0] chars[$];
        bit         ctl[$];
        int         n;
        blk_t       blk;
        n = (len < 46) ? 46 : ((len > 1500) ? 1500 : len);
        exp_q.delete();
        exp_q.push_back('{c: 8'h01, d: 64'hD5555555555555FB});
        for (int i = 0; i < n; i++) begin
            chars.push_back(8'((i + fc) % 256));
            ctl.push_back(1'b0);
        end
        chars.push_back(8'hFD);
        ctl.push_back(1'b1);
        while (chars.size() % 8 != 0) begin
            chars.push_back(8'h07);
            ctl.push_back(1'b1);
        end
        for (int b = 0; b < chars.size() / 8; b++) begin
            for (int l = 0; l < 8; l++) begin
                blk.d[8*l +: 8] = chars[8*b + l];
                blk.c[l]        = ctl[8*b + l];
            end
            exp_q.push_back(blk);
        end
    endfunction

    task automatic applyStimulus(input int len, input int ifg, input bit cont);
        cfg_payload_len = 11'(len);
        cfg_ifg         = 4'(ifg);
        cfg_continuous  = cont;
        start           = 1'b1;
        tick();
        start           = 1'b0;
        checkOutput("busy on accept", 64'(busy), 64'd1);
    endtask

    task automatic followFrame(input int len, input bit scramble, input bit poke,
                               output int full_seen, output logic [7:0] last_c,
                               output logic [63:0] first_data, output logic [63:0] last_d);
        int   bad_blk;
        int   bad_fc;
        int   bad_busy;
        bit   ended;
        blk_t act;
        bad_blk   = 0;
        bad_fc    = 0;
        bad_busy  = 0;
        ended     = 1'b0;
        full_seen = 0;
        last_c    = 8'h00;
        first_data = '0;
        last_d    = '0;
        modelFrame(len, exp_fc);
        for (int b = 0; b < exp_q.size(); b++) begin
            tick();
            act.c = xg_if.xgmii_txc;
            act.d = xg_if.xgmii_txd;
            if (b == 1) first_data = act.d;
            last_d = act.d;
            if (b > 0 && !ended) begin
                if (act.c == 8'h00) begin
                    full_seen++;
                end else begin
                    last_c = act.c;
                    ended  = 1'b1;
                end
            end
            if (act !== exp_q[b]) begin
                if (bad_blk == 0)
                    $display("[TB] first block difference at %0d: got %h_%h want %h_%h",
                             b, act.c, act.d, exp_q[b].c, exp_q[b].d);
                bad_blk++;
            end
            if (frame_count !== 32'(exp_fc + ((b == exp_q.size() - 1) ? 1 : 0))) bad_fc++;
            if (busy !== 1'b1) bad_busy++;
            if (scramble) begin
                cfg_payload_len = 11'($urandom);
                cfg_ifg         = 4'($urandom);
            end
            if (poke) start = (b == 2);
        end
        start = 1'b0;
        exp_fc++;
        checkOutput($sformatf("stream len=%0d bad blocks", len), 64'(bad_blk), 64'd0);
        checkOutput($sformatf("frame_count timing len=%0d", len), 64'(bad_fc), 64'd0);
        checkOutput($sformatf("busy in frame len=%0d", len), 64'(bad_busy), 64'd0);
    endtask

    task automatic checkIfg(input int ifg, input bit cont);
        int eff;
        int bad;
        eff = (ifg == 0) ? 1 : ifg;
        bad = 0;
        for (int k = 0; k < eff; k++) begin
            tick();
            if (xg_if.xgmii_txd !== IDLE_BLOCK || xg_if.xgmii_txc !== 8'hFF) bad++;
            if (busy !== (cont || (k < eff - 1))) bad++;
        end
        checkOutput($sformatf("ifg gap of %0d", eff), 64'(bad), 64'd0);
    endtask

    task automatic runFrame(input int len, input int ifg, input bit scramble, input bit poke,
                            output int full_seen, output logic [7:0] last_c, output logic [63:0] last_d);
        logic [63:0] first_data;
        int          bad;
        applyStimulus(len, ifg, 1'b0);
        followFrame(len, scramble, poke, full_seen, last_c, first_data, last_d);
        checkIfg(ifg, 1'b0);
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (xg_if.xgmii_txd !== IDLE_BLOCK || xg_if.xgmii_txc !== 8'hFF || busy !== 1'b0) bad++;
        end
        checkOutput("quiet after frame", 64'(bad), 64'd0);
    endtask

    initial begin
        vec_t        vecs[9];
        int          full;
        logic [7:0]  lc;
        logic [63:0] ld;
        logic [63:0] fd;
        int          bad;

        vecs[0] = '{46,   5,   8'hC0};
        vecs[1] = '{10,   5,   8'hC0};
        vecs[2] = '{48,   6,   8'hFF};
        vecs[3] = '{47,   5,   8'h80};
        vecs[4] = '{53,   6,   8'hE0};
        vecs[5] = '{56,   7,   8'hFF};
        vecs[6] = '{1500, 187, 8'hF0};
        vecs[7] = '{1501, 187, 8'hF0};
        vecs[8] = '{2000, 187, 8'hF0};

        tx_rst_n        = 1'b0;
        start           = 1'b0;
        cfg_payload_len = 11'd46;
        cfg_ifg         = 4'd1;
        cfg_continuous  = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        checkOutput("reset txd", xg_if.xgmii_txd, IDLE_BLOCK);
        checkOutput("reset txc", 64'(xg_if.xgmii_txc), 64'hFF);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset frame_count", 64'(frame_count), 64'd0);
        tx_rst_n = 1'b1;
        tick();

        // Minimum frame right after reset: last block 0x28..0x2D, terminate lane 6.
        runFrame(46, 1, 1'b0, 1'b1, full, lc, ld);
        checkOutput("len46 last block", ld, 64'h07FD2D2C2B2A2928);
        checkOutput("len46 frame_count", 64'(frame_count), 64'd1);

        for (int i = 0; i < 9; i++) begin
            runFrame(vecs[i].len, 2, 1'b0, 1'b0, full, lc, ld);
            checkOutput($sformatf("len=%0d full blocks", vecs[i].len), 64'(full), 64'(vecs[i].full));
            checkOutput($sformatf("len=%0d final txc", vecs[i].len), 64'(lc), 64'(vecs[i].last_c));
        end

        // Back-to-back frames with the programmed gap; frame 2 byte 0 follows the count.
        for (int g = 0; g < 2; g++) begin
            int ifg;
            int fc_first;
            ifg      = (g == 0) ? 0 : 3;
            fc_first = exp_fc;
            applyStimulus(46, ifg, 1'b1);
            followFrame(46, 1'b0, 1'b0, full, lc, fd, ld);
            checkIfg(ifg, 1'b1);
            followFrame(46, 1'b0, 1'b0, full, lc, fd, ld);
            checkOutput($sformatf("continuous ifg=%0d frame2 byte0", ifg), 64'(fd[7:0]),
                        64'((fc_first + 1) % 256));
            cfg_continuous = 1'b0;
            checkIfg(ifg, 1'b0);
        end

        // Reset in the middle of the payload abandons the frame with no terminate.
        applyStimulus(200, 1, 1'b0);
        for (int k = 0; k < 4; k++) tick();
        tx_rst_n = 1'b0;
        #1;
        checkOutput("mid-frame reset txd", xg_if.xgmii_txd, IDLE_BLOCK);
        checkOutput("mid-frame reset txc", 64'(xg_if.xgmii_txc), 64'hFF);
        checkOutput("mid-frame reset busy", 64'(busy), 64'd0);
        checkOutput("mid-frame reset frame_count", 64'(frame_count), 64'd0);
        exp_fc = 0;
        tick();
        tx_rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (xg_if.xgmii_txd !== IDLE_BLOCK || xg_if.xgmii_txc !== 8'hFF || busy !== 1'b0) bad++;
        end
        checkOutput("idle after mid-frame reset", 64'(bad), 64'd0);
        runFrame(46, 1, 1'b0, 1'b0, full, lc, ld);

        for (int r = 0; r < 15; r++) begin
            int len;
            int ifg;
            len = int'($urandom_range(2047, 0));
            ifg = int'($urandom_range(15, 0));
            runFrame(len, ifg, 1'b1, 1'($urandom), full, lc, ld);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xgmii_frame_gen.md
XGMII_FRAME_GEN -- requirements
Module: xgmii_frame_gen

Interface
REQ-001 SHALL expose parameter DATA_WIDTH, default 64, XGMII data width; only 64 supported.
REQ-002 SHALL expose parameter CTRL_WIDTH, default DATA_WIDTH/8, XGMII control width.
REQ-003 SHALL have port tx_clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port tx_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  single-cycle request to send one frame.
REQ-006 SHALL have port cfg_payload_len  input  11  payload length in bytes.
REQ-007 SHALL have port cfg_ifg  input  4  idle blocks between frames.
REQ-008 SHALL have port cfg_continuous  input  1  back-to-back frames while high.
REQ-009 SHALL have port xgmii_txd  output  DATA_WIDTH  XGMII data to eth_phy_10g xgmii_txd; lane n = bits [8n+7:8n].
REQ-010 SHALL have port xgmii_txc  output  CTRL_WIDTH  XGMII control to eth_phy_10g xgmii_txc; bit n = lane n.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port frame_count  output  32  completed frames, wraps at 2^32.

Function
REQ-013 SHALL register all outputs; an output block SHALL appear 1 cycle after the state/decision that selects it.
REQ-014 SHALL implement states IDLE, START, DATA, TERM, IFG.
REQ-015 IDLE: output idle block (txd 64'h0707070707070707, txc 8'hFF); start=1 -> START.
REQ-016 START: output txd 64'hD5555555555555FB, txc 8'h01; latch config; -> DATA.
REQ-017 Config latch: len<46 -> 46, len>1500 -> 1500; cfg_ifg=0 -> 1; config changes mid-frame SHALL be ignored.
REQ-018 Payload byte i (0-based) SHALL equal (i + frame_count[7:0]) mod 256, lane order ascending.
REQ-019 DATA with rem>8: 8 data bytes, txc 8'h00, rem -= 8.
REQ-020 DATA with rem==8: 8 data bytes, txc 8'h00, -> TERM.
REQ-021 DATA with rem<8: lanes 0..rem-1 data, lane rem 0xFD, lanes above 0x07; txc bits rem..7 set; -> IFG.
REQ-022 TERM: txd 64'h07070707070707FD, txc 8'hFF; -> IFG.
REQ-023 frame_count SHALL increment in the same cycle the block carrying 0xFD is emitted.
REQ-024 IFG: emit latched-ifg idle blocks, then START if cfg_continuous=1, else IDLE.
REQ-025 start asserted while busy=1 SHALL be ignored (not queued).
REQ-026 No FCS SHALL be appended; xgmii_txc SHALL never flag a data lane.

Reset
REQ-027 tx_rst_n low SHALL immediately force state IDLE, xgmii_txd 64'h0707070707070707, xgmii_txc 8'hFF, busy 0, frame_count 0, counters 0.
REQ-028 Reset mid-frame SHALL abandon the frame without emitting a terminate; first post-reset block is idle.

Structure
REQ-029 XGMII constants (IDLE 8'h07, START 8'hFB, TERM 8'hFD, PRE 8'h55, SFD 8'hD5) and the state encoding SHALL live in a shared package xgmii_pkg reused by the PHY benches.
REQ-030 Block assembly SHALL be one sub-module xgmii_term_mux (combinational: rem, data word -> txd/txc for partial-terminate blocks); FSM and counters stay in xgmii_frame_gen.

Verification
REQ-031 Reset: tx_rst_n=0 -> txd 64'h0707070707070707, txc 8'hFF, busy 0, frame_count 0.
REQ-032 len=46, ifg=1, start pulse -> START block next cycle, 5 data blocks (bytes 0x00..0x27), final block lanes0-5 0x28..0x2D, lane6 0xFD, lane7 0x07, txc 8'hC0, frame_count=1, then 1 idle, busy 0.
REQ-033 len=48 -> 6 data blocks (0x00..0x2F), then 64'h07070707070707FD txc 8'hFF.
REQ-034 Clamp: len=10 -> identical to len=46; len=2000 -> 187 full data blocks, last block 4 data lanes, 0xFD lane4, txc 8'hF0.
REQ-035 cfg_continuous=1, ifg=0 -> exactly 1 idle between frames; frame 2 byte0 = 0x01; start pulses during frame ignored.
REQ-036 tx_rst_n low during DATA -> outputs idle same cycle, no 0xFD emitted, frame_count 0; through eth_phy_10g loopback xgmii_rxd SHALL reproduce the generated stream.
